// File: rtl/data_mem_ctrl.sv
// Word-array data memory with req/ack handshake, programmable wait states and LB/LBU/LH/LHU/LW/SB/SH/SW.
// Optional misaligned-access trap: define MISALIGN_TRAP_EN (default build forces alignment instead).
module data_mem_ctrl #(
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        misalign
);
    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
    state_t state, state_nx;

    logic [3:0]  wcnt;
    logic        we_q, sx_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]  off;
    logic [4:0]  off8;
    logic [3:0]  be;
    logic [31:0] rd_word, rd_sh, wd_sh, wr_word, ld_data;
    logic        mis;

    // Index bits between DEPTH_LOG2 and 31 alias onto the same word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_q[30:DEPTH_LOG2+1];

    assign idx     = {addr_q[31], addr_q[DEPTH_LOG2:2]};
    assign rd_word = mem[idx];
    assign busy    = (state != IDLE);

    always_comb begin
        off = 2'b00;
        be  = 4'b1111;
        case (size_q)
            2'b00: begin off = addr_q[1:0];         be = 4'b0001 << addr_q[1:0]; end
            2'b01: begin off = {addr_q[1], 1'b0};   be = 4'b0011 << {addr_q[1], 1'b0}; end
            default: ;
        endcase
        off8  = {off, 3'b000};
        rd_sh = rd_word >> off8;
        wd_sh = wdata_q << off8;
        for (int i = 0; i < 4; i++)
            wr_word[8*i +: 8] = be[i] ? wd_sh[8*i +: 8] : rd_word[8*i +: 8];
        case (size_q)
            2'b00:   ld_data = {{24{sx_q & rd_sh[7]}},  rd_sh[7:0]};
            2'b01:   ld_data = {{16{sx_q & rd_sh[15]}}, rd_sh[15:0]};
            default: ld_data = rd_word;
        endcase
`ifdef MISALIGN_TRAP_EN
        mis = (size_q == 2'b01 && addr_q[0]) || (size_q[1] && addr_q[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            WAIT:    if (wcnt == WLAST) state_nx = ACCESS;
            ACCESS:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ack      <= 1'b0;
            rdata    <= 32'h0;
            misalign <= 1'b0;
            wcnt     <= 4'h0;
        end else begin
            state    <= state_nx;
            ack      <= (state == ACCESS);
            misalign <= (state == ACCESS) && mis;
            wcnt     <= (state == WAIT) ? wcnt + 4'h1 : 4'h0;
            if (state == ACCESS && !we_q && !mis)
                rdata <= ld_data;
            if (state == IDLE && req) begin
                we_q    <= we;
                size_q  <= size;
                sx_q    <= sign_ext;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // Array contents survive reset; a reset in ACCESS suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && we_q && !mis)
            mem[idx] <= wr_word;
    end
endmodule
